a_plus_b_fifo_adder: RTL and testbench

A_PLUS_B_FIFO_ADDER -- requirements
Module: a_plus_b_fifo_adder

---
 rtl/a_plus_b_fifo_adder.sv | 119 +++++++++++
 tb/tb_a_plus_b_fifo_adder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_plus_b_fifo_adder.sv
// a_plus_b_fifo_adder: pops one operand from each of two show-ahead FIFOs
// when both are non-empty and the result buffer has room. It presents
// a_data + b_data (zero-extended, width+1 bits) one cycle later under a
// valid/ready handshake, and counts the consumed pairs.
//
// Build option: APLUS_B_FIFO_ADDER_SKID_EN
//   undefined -> single-entry result buffer. It can accept while draining,
//                so the pop decision looks at sum_ready combinationally.
//   defined   -> two-entry skid buffer. Acceptance depends only on the
//                buffer occupancy, so there is no ready-to-pop path.
module a_plus_b_fifo_adder #(
  parameter int width       = 2,
  parameter int count_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_empty,
  input  logic [width-1:0]       a_data,
  output logic                   a_pop,
  input  logic                   b_empty,
  input  logic [width-1:0]       b_data,
  output logic                   b_pop,
  output logic                   sum_valid,
  input  logic                   sum_ready,
  output logic [width:0]         sum,
  output logic [count_width-1:0] pair_count
);

  logic                   accept;
  logic                   fire;
  logic [width:0]         add_res;
  logic [count_width-1:0] cnt_q, cnt_d;

  // The pop is gated by rst so that it drops asynchronously during reset.
  assign add_res = {1'b0, a_data} + {1'b0, b_data};
  assign fire    = rst & ~a_empty & ~b_empty & accept;
  assign a_pop   = fire;
  assign b_pop   = fire;

  // Next value of the pair counter; it wraps naturally at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (fire) cnt_d = cnt_q + {{(count_width-1){1'b0}}, 1'b1};
  end

  // Pair counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign pair_count = cnt_q;

`ifdef APLUS_B_FIFO_ADDER_SKID_EN
  logic [1:0]            occ_q, occ_d;
  logic [1:0][width:0]   ent_q;
  logic                  rd_q, wr_q;
  logic                  drain;

  assign accept    = (occ_q < 2'd2);
  assign drain     = (occ_q != 2'd0) & sum_ready;
  assign sum_valid = (occ_q != 2'd0);
  assign sum       = ent_q[rd_q];

  // Occupancy tracking; a fire and a drain in the same cycle cancel out.
  always_comb begin
    occ_d = occ_q + {1'b0, fire} - {1'b0, drain};
  end

  // Two-slot ring: write at wr_q on fire, and advance rd_q on drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
      ent_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (fire) begin
        ent_q[wr_q] <= add_res;
        wr_q        <= ~wr_q;
      end
      if (drain) rd_q <= ~rd_q;
    end
  end
`else
  logic           valid_q, valid_d;
  logic [width:0] sum_q, sum_d;

  // The slot frees up in the same cycle that downstream takes it.
  assign accept    = ~valid_q | sum_ready;
  assign sum_valid = valid_q;
  assign sum       = sum_q;

  // A fire (re)loads the slot. A drain without a fire empties it.
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    if (fire) begin
      valid_d = 1'b1;
      sum_d   = add_res;
    end else if (sum_ready) begin
      valid_d = 1'b0;
    end
  end

  // Single-entry result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
    end
  end
`endif

endmodule

// File: tb/tb_a_plus_b_fifo_adder.sv
// Testbench for a_plus_b_fifo_adder. The two upstream FIFOs are modelled
// as queues. The reference model is a queue of results that have been
// popped but not yet delivered: its size is the buffer occupancy, and its
// head is the value that downstream must see next. A second instance with
// count_width=4 shares all inputs and checks the counter wrap.
module tb_a_plus_b_fifo_adder;
  localparam int W  = 2;
  localparam int SW = W + 1;
`ifdef APLUS_B_FIFO_ADDER_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          a_empty, b_empty, sum_ready;
  logic [W-1:0]  a_data, b_data;
  logic          a_pop, b_pop, sum_valid;
  logic [W:0]    sum;
  logic [15:0]   pair_count;
  logic          a_pop4, b_pop4, sum_valid4;
  logic [W:0]    sum4;
  logic [3:0]    pair_count4;

  int tests = 0;
  int fails = 0;
  int qa[$], qb[$], expq[$], dlv[$];
  int pops = 0;
  int rdy_mode = 0;  // 0: ready=1, 1: ready=0, 2: toggle, 3: random
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [W:0] prev_sum = '0;

  always #5 clk = ~clk;

  a_plus_b_fifo_adder #(.width(W), .count_width(16)) dut (
    .clk(clk), .rst(rst),
    .a_empty(a_empty), .a_data(a_data), .a_pop(a_pop),
    .b_empty(b_empty), .b_data(b_data), .b_pop(b_pop),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum(sum),
    .pair_count(pair_count)
  );

  a_plus_b_fifo_adder #(.width(W), .count_width(4)) dut4 (
    .clk(clk), .rst(rst),
    .a_empty(a_empty), .a_data(a_data), .a_pop(a_pop4),
    .b_empty(b_empty), .b_data(b_data), .b_pop(b_pop4),
    .sum_valid(sum_valid4), .sum_ready(sum_ready), .sum(sum4),
    .pair_count(pair_count4)
  );

  task automatic drive_fifo();
    a_empty = (qa.size() == 0);
    b_empty = (qb.size() == 0);
    a_data  = a_empty ? '0 : W'(qa[0]);
    b_data  = b_empty ? '0 : W'(qb[0]);
  endtask

  task automatic push_pair(input int a, input int b);
    qa.push_back(a);
    qb.push_back(b);
  endtask

  // One clock cycle: check at the negedge, then update the FIFOs and the
  // stimulus #1 after the posedge.
  task automatic tick();
    logic popped;
    @(negedge clk);
    tests++;
    if (a_pop !== b_pop || (a_pop === 1'b1 && (a_empty || b_empty))) begin
      fails++;
      $display("FAIL pop_rule a_pop=%b b_pop=%b a_empty=%b b_empty=%b", a_pop, b_pop, a_empty, b_empty);
    end
    tests++;
    if ({a_pop4, b_pop4, sum_valid4, sum4} !== {a_pop, b_pop, sum_valid, sum}) begin
      fails++;
      $display("FAIL cw4_match got %b%b%b%0d want %b%b%b%0d", a_pop4, b_pop4, sum_valid4, sum4, a_pop, b_pop, sum_valid, sum);
    end
    tests++;
    if (sum_valid !== (expq.size() != 0)) begin
      fails++;
      $display("FAIL occupancy sum_valid=%b want %b (pending=%0d)", sum_valid, expq.size() != 0, expq.size());
    end
    if (prev_v && !prev_r) begin
      tests++;
      if (sum_valid !== 1'b1 || sum !== prev_sum) begin
        fails++;
        $display("FAIL hold got v=%b sum=%0d want v=1 sum=%0d", sum_valid, sum, prev_sum);
      end
    end
    if (sum_valid === 1'b1 && sum_ready && expq.size() != 0) begin
      tests++;
      if (sum !== SW'(expq[0])) begin
        fails++;
        $display("FAIL order got sum=%0d want %0d", sum, expq[0]);
      end
      dlv.push_back(int'(sum));
      void'(expq.pop_front());
    end
    tests++;
    if (pair_count !== 16'(pops) || pair_count4 !== 4'(pops)) begin
      fails++;
      $display("FAIL pair_count got %0d/%0d want %0d/%0d", pair_count, pair_count4, 16'(pops), 4'(pops));
    end
    popped = (a_pop === 1'b1) && qa.size() != 0 && qb.size() != 0;
    if (popped) begin
      expq.push_back(qa[0] + qb[0]);
      pops++;
    end
    prev_v   = sum_valid;
    prev_r   = sum_ready;
    prev_sum = sum;
    @(posedge clk);
    #1;
    if (popped) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    case (rdy_mode)
      0:       sum_ready = 1'b1;
      1:       sum_ready = 1'b0;
      2:       sum_ready = ~sum_ready;
      default: sum_ready = 1'($urandom_range(0, 1));
    endcase
    drive_fifo();
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((qa.size() > 0 && qb.size() > 0) || expq.size() > 0) begin
      if (n >= max) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout got pending=%0d want 0 after %0d cycles", expq.size(), max);
        return;
      end
      tick();
      n++;
    end
  endtask

  // Asynchronous reset pulse applied between clock edges; the model drops
  // any undelivered results, and the FIFO contents stay in place.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    tests++;
    if (a_pop !== 1'b0 || sum_valid !== 1'b0 || sum !== '0 || pair_count !== '0 || pair_count4 !== '0) begin
      fails++;
      $display("FAIL async_reset got pop=%b v=%b sum=%0d cnt=%0d want 0 0 0 0", a_pop, sum_valid, sum, pair_count);
    end
    expq.delete();
    pops   = 0;
    prev_v = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rdy_mode = 0;
    sum_ready = 1'b1;
    push_pair(1, 3);
    push_pair(2, 0);
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (a_pop !== 1'b0 || b_pop !== 1'b0 || sum_valid !== 1'b0 || sum !== '0 || pair_count !== '0 || pair_count4 !== '0) begin
      fails++;
      $display("FAIL reset_state got pop=%b%b v=%b sum=%0d cnt=%0d want 00 0 0 0", a_pop, b_pop, sum_valid, sum, pair_count);
    end
    rst = 1'b1;
    prev_v = 1'b0;
    run_idle(20);
  endtask

  task automatic test_basic();
    do_reset();
    rdy_mode = 0;
    sum_ready = 1'b1;
    dlv.delete();
    push_pair(3, 2);
    push_pair(1, 3);
    drive_fifo();
    tick();
    tick();
    tests++;
    if (pops != 2) begin
      fails++;
      $display("FAIL basic_pops got %0d want 2", pops);
    end
    run_idle(10);
    tests++;
    if (dlv.size() != 2 || dlv[0] != 5 || dlv[1] != 4 || pair_count !== 16'd2) begin
      fails++;
      $display("FAIL basic_sums got n=%0d cnt=%0d want 5,4 cnt=2", dlv.size(), pair_count);
    end
  endtask

  task automatic test_wait_b();
    int base;
    rdy_mode = 0;
    dlv.delete();
    qa.push_back(1);
    drive_fifo();
    base = pops;
    repeat (5) tick();
    tests++;
    if (pops != base) begin
      fails++;
      $display("FAIL wait_b_nopop got %0d pops want 0", pops - base);
    end
    qb.push_back(2);
    drive_fifo();
    run_idle(10);
    tests++;
    if (pops != base + 1 || dlv.size() != 1 || dlv[0] != 3) begin
      fails++;
      $display("FAIL wait_b_sum got pops=%0d n=%0d want pops=1 sum=3", pops - base, dlv.size());
    end
  endtask

  task automatic test_backpressure();
    int base;
    rdy_mode = 1;
    sum_ready = 1'b0;
    dlv.delete();
    repeat (3) push_pair(3, 3);
    drive_fifo();
    base = pops;
    repeat (6) tick();
    tests++;
    if (pops - base != DEPTH || sum_valid !== 1'b1 || sum !== 3'd6) begin
      fails++;
      $display("FAIL backpressure got pops=%0d v=%b sum=%0d want pops=%0d v=1 sum=6", pops - base, sum_valid, sum, DEPTH);
    end
    tests++;
    if (qa.size() != 3 - DEPTH || qb.size() != 3 - DEPTH) begin
      fails++;
      $display("FAIL fifo_untouched got %0d/%0d want %0d", qa.size(), qb.size(), 3 - DEPTH);
    end
    rdy_mode = 0;
    sum_ready = 1'b1;
    run_idle(20);
    tests++;
    if (dlv.size() != 3 || dlv[0] != 6 || dlv[1] != 6 || dlv[2] != 6) begin
      fails++;
      $display("FAIL backpressure_drain got n=%0d want three 6s", dlv.size());
    end
  endtask

  task automatic test_toggle();
    int want[$];
    int a, b;
    do_reset();
    dlv.delete();
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      push_pair(a, b);
      want.push_back(a + b);
    end
    drive_fifo();
    run_idle(60);
    tests++;
    if (dlv.size() != 8 || pair_count !== 16'd8) begin
      fails++;
      $display("FAIL toggle_count got n=%0d cnt=%0d want 8 8", dlv.size(), pair_count);
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (dlv[i] != want[i]) begin
          fails++;
          $display("FAIL toggle_seq[%0d] got %0d want %0d", i, dlv[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    rdy_mode = 1;
    sum_ready = 1'b0;
    dlv.delete();
    repeat (3) push_pair(2, 1);
    drive_fifo();
    repeat (3) tick();
    tests++;
    if (sum_valid !== 1'b1) begin
      fails++;
      $display("FAIL midreset_pre got v=%b want 1", sum_valid);
    end
    do_reset();
    rdy_mode = 0;
    sum_ready = 1'b1;
    run_idle(20);
    tests++;
    if (dlv.size() != 3 - DEPTH || pair_count !== 16'(3 - DEPTH)) begin
      fails++;
      $display("FAIL midreset_resume got n=%0d cnt=%0d want %0d", dlv.size(), pair_count, 3 - DEPTH);
    end
  endtask

  task automatic test_random();
    rdy_mode = 3;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) qa.push_back($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) qb.push_back($urandom_range(0, 3));
      drive_fifo();
      tick();
    end
    while (qa.size() < qb.size()) qa.push_back($urandom_range(0, 3));
    while (qb.size() < qa.size()) qb.push_back($urandom_range(0, 3));
    drive_fifo();
    run_idle(400);
  endtask

  task automatic test_wrap();
    do_reset();
    rdy_mode = 0;
    sum_ready = 1'b1;
    repeat (17) push_pair($urandom_range(0, 3), $urandom_range(0, 3));
    drive_fifo();
    run_idle(60);
    tests++;
    if (pair_count4 !== 4'd1 || pair_count !== 16'd17) begin
      fails++;
      $display("FAIL wrap got cnt4=%0d cnt=%0d want 1 17", pair_count4, pair_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_b();
    test_backpressure();
    test_toggle();
    test_reset_midstream();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
